// File: rtl/prog_clk_divider_if.sv
// Configuration port of prog_clk_divider: one request selects a channel and
// carries a new divisor and high count.
interface prog_clk_divider_if #(
  parameter int CH_W  = 1,
  parameter int DIV_W = 26
);
  // valid/ready: a request transfers on any clk_in edge where cfg_valid && cfg_ready.
  // The master holds cfg_ch/cfg_div/cfg_high stable while cfg_valid is high and
  // not yet accepted. cfg_ready depends only on cfg_ch and registered state.
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_high;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_high,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_high,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock/tick generator: each channel divides clk_in by
// N with a high time of H; new N/H land glitch-free at the channel's next wrap.
module prog_clk_divider #(
  parameter int CLK_FREQ = 50,
  parameter int NUM_CH   = 2,
  parameter int CH_W     = 1,
  parameter int DIV_W    = 26
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               en,
  input  logic               sync_in,
  prog_clk_divider_if.slave  cfg,
  output logic [NUM_CH-1:0]  clk_out,
  output logic [NUM_CH-1:0]  tick
);

  localparam int               CH_SLOTS = 1 << CH_W;
  localparam logic [DIV_W-1:0] RST_N    = DIV_W'(CLK_FREQ);
  localparam logic [DIV_W-1:0] RST_H    = DIV_W'(CLK_FREQ / 2);

  logic [DIV_W-1:0]    cnt     [NUM_CH];
  logic [DIV_W-1:0]    n_r     [NUM_CH];
  logic [DIV_W-1:0]    h_r     [NUM_CH];
  logic [DIV_W-1:0]    sh_n    [NUM_CH];
  logic [DIV_W-1:0]    sh_h    [NUM_CH];
  logic [DIV_W-1:0]    cnt_nxt [NUM_CH];
  logic [DIV_W-1:0]    thr     [NUM_CH];
  logic [NUM_CH-1:0]   wrap;
  logic [NUM_CH-1:0]   pending;
  logic [CH_SLOTS-1:0] pend_ext;
  logic                xfer;
  logic                cfg_ok;

  // Out-of-range channel numbers see a zero pending bit, so they are accepted
  // (and then flagged as invalid) instead of stalling the port.
  always_comb begin
    pend_ext                 = '0;
    pend_ext[NUM_CH-1:0]     = pending;
  end

  assign cfg.cfg_ready = !pend_ext[cfg.cfg_ch];
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg_ok        = (32'(cfg.cfg_ch) < NUM_CH) &&
                         (cfg.cfg_div >= DIV_W'(2)) &&
                         (cfg.cfg_high != '0) &&
                         (cfg.cfg_high < cfg.cfg_div);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i]    = (cnt[i] == n_r[i] - DIV_W'(1));
      cnt_nxt[i] = wrap[i] ? '0 : cnt[i] + DIV_W'(1);
      thr[i]     = n_r[i] - h_r[i];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]  <= '0;
        n_r[i]  <= RST_N;
        h_r[i]  <= RST_H;
        sh_n[i] <= RST_N;
        sh_h[i] <= RST_H;
      end
      clk_out     <= '0;
      tick        <= '0;
      pending     <= '0;
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= xfer && !cfg_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_in) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
          if (pending[i]) begin
            n_r[i]     <= sh_n[i];
            h_r[i]     <= sh_h[i];
            pending[i] <= 1'b0;
          end
        end else if (en) begin
          cnt[i]     <= cnt_nxt[i];
          clk_out[i] <= (cnt_nxt[i] >= thr[i]);
          tick[i]    <= wrap[i];
          // At a wrap cnt_nxt is 0, which is below any legal N-H, so clk_out
          // goes low whether or not the shadow is applied here.
          if (wrap[i] && pending[i]) begin
            n_r[i]     <= sh_n[i];
            h_r[i]     <= sh_h[i];
            pending[i] <= 1'b0;
          end
        end else begin
          tick[i] <= 1'b0;
        end
        if (xfer && cfg_ok && (cfg.cfg_ch == CH_W'(i))) begin
          sh_n[i]    <= cfg.cfg_div;
          sh_h[i]    <= cfg.cfg_high;
          pending[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider (CLK_FREQ=50, two channels, CH_W=2 so an
// out-of-range channel number can be driven). k counts clk_in edges since reset release.
module tb_prog_clk_divider;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 2;
  localparam int DIV_W  = 26;

  logic              clk_in = 1'b0;
  logic              rst;
  logic              en;
  logic              sync_in;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  prog_clk_divider_if #(.CH_W(CH_W), .DIV_W(DIV_W)) cfg_if ();

  prog_clk_divider #(
    .CLK_FREQ (50),
    .NUM_CH   (NUM_CH),
    .CH_W     (CH_W),
    .DIV_W    (DIV_W)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .sync_in (sync_in),
    .cfg     (cfg_if),
    .clk_out (clk_out),
    .tick    (tick)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  int k;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         k;
    logic [1:0] clk;
    logic [1:0] tk;
  } vec_t;

  vec_t tbl[8];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
    k++;
  endtask

  task automatic adv_to(input int target);
    while (k < target) step();
  endtask

  task automatic drive_cfg(input logic v, input logic [CH_W-1:0] ch,
                           input logic [DIV_W-1:0] n, input logic [DIV_W-1:0] h);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_div   = n;
    cfg_if.cfg_high  = h;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    sync_in = 1'b0;
    drive_cfg(1'b0, '0, '0, '0);
    k = 0;
    repeat (3) step();
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    chk("rst_err", 32'(cfg_if.cfg_err), 32'd0);
    rst = 1'b0;
    k = 0;

    // 1. defaults: 25 low / 25 high, tick every 50, channels in phase
    tbl[0] = '{1,   2'b00, 2'b00};
    tbl[1] = '{24,  2'b00, 2'b00};
    tbl[2] = '{25,  2'b11, 2'b00};
    tbl[3] = '{49,  2'b11, 2'b00};
    tbl[4] = '{50,  2'b00, 2'b11};
    tbl[5] = '{51,  2'b00, 2'b00};
    tbl[6] = '{75,  2'b11, 2'b00};
    tbl[7] = '{100, 2'b00, 2'b11};
    for (int i = 0; i < 8; i++) begin
      adv_to(tbl[i].k);
      chk("dflt_clk_out", 32'(clk_out), 32'(tbl[i].clk));
      chk("dflt_tick", 32'(tick), 32'(tbl[i].tk));
    end

    // 2. ch1 -> N=10,H=3 mid-period; lands at ch1's wrap (k=150)
    adv_to(110);
    drive_cfg(1'b1, 2'd1, 26'd10, 26'd3);
    chk("cfg2_ready_before", 32'(cfg_if.cfg_ready), 32'd1);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("cfg2_ready_pending", 32'(cfg_if.cfg_ready), 32'd0);
    chk("cfg2_err", 32'(cfg_if.cfg_err), 32'd0);
    adv_to(149);
    chk("cfg2_ready_149", 32'(cfg_if.cfg_ready), 32'd0);
    chk("cfg2_clk_149", 32'(clk_out), 32'b11);
    adv_to(150);
    chk("cfg2_tick_150", 32'(tick), 32'b11);
    chk("cfg2_ready_150", 32'(cfg_if.cfg_ready), 32'd1);
    adv_to(156);
    chk("ch1_low_156", 32'(clk_out), 32'b00);
    adv_to(157);
    chk("ch1_high_157", 32'(clk_out), 32'b10);
    adv_to(160);
    chk("ch1_tick_160", 32'(tick), 32'b10);
    adv_to(175);
    chk("ch0_high_175", 32'(clk_out[0]), 32'd1);

    // 3. invalid configs on ch0 and on nonexistent ch3
    adv_to(176);
    drive_cfg(1'b1, 2'd0, 26'd1, 26'd0);
    chk("inv_ready", 32'(cfg_if.cfg_ready), 32'd1);
    step();
    chk("inv_err_n1", 32'(cfg_if.cfg_err), 32'd1);
    drive_cfg(1'b1, 2'd0, 26'd8, 26'd8);
    step();
    chk("inv_err_heqn", 32'(cfg_if.cfg_err), 32'd1);
    chk("inv_ready_ch0", 32'(cfg_if.cfg_ready), 32'd1);
    drive_cfg(1'b1, 2'd3, 26'd4, 26'd2);
    chk("inv_ready_ch3", 32'(cfg_if.cfg_ready), 32'd1);
    step();
    chk("inv_err_ch3", 32'(cfg_if.cfg_err), 32'd1);
    drive_cfg(1'b0, 2'd0, 26'd0, 26'd0);
    step();
    chk("inv_err_clear", 32'(cfg_if.cfg_err), 32'd0);
    chk("inv_ready_after", 32'(cfg_if.cfg_ready), 32'd1);
    adv_to(199);
    chk("inv_ch0_high_199", 32'(clk_out[0]), 32'd1);
    adv_to(200);
    chk("inv_tick_200", 32'(tick), 32'b11);

    // 4. stall 5 cycles at ch0 cnt=30
    adv_to(230);
    chk("stall_clk_230", 32'(clk_out), 32'b01);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_tick", 32'(tick), 32'b00);
      chk("stall_clk", 32'(clk_out), 32'b01);
    end
    en = 1'b1;
    adv_to(250);
    chk("stall_no_tick_250", 32'(tick), 32'b00);
    adv_to(254);
    chk("stall_ch0_high_254", 32'(clk_out[0]), 32'd1);
    adv_to(255);
    chk("stall_tick_255", 32'(tick), 32'b11);
    chk("stall_clk_255", 32'(clk_out), 32'b00);

    // 5. ch1 pending N=4,H=2, sync at ch0 cnt=17
    adv_to(266);
    drive_cfg(1'b1, 2'd1, 26'd4, 26'd2);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("sync_ready_pending", 32'(cfg_if.cfg_ready), 32'd0);
    adv_to(272);
    chk("sync_clk0_before", 32'(clk_out[0]), 32'd0);
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    chk("sync_clk_273", 32'(clk_out), 32'b00);
    chk("sync_tick_273", 32'(tick), 32'b00);
    chk("sync_ready_273", 32'(cfg_if.cfg_ready), 32'd1);
    adv_to(274);
    chk("sync_clk_274", 32'(clk_out), 32'b00);
    adv_to(275);
    chk("sync_clk_275", 32'(clk_out), 32'b10);
    adv_to(276);
    chk("sync_clk_276", 32'(clk_out), 32'b10);
    adv_to(277);
    chk("sync_tick_277", 32'(tick), 32'b10);
    chk("sync_clk_277", 32'(clk_out), 32'b00);
    adv_to(297);
    chk("sync_ch0_low_297", 32'(clk_out[0]), 32'd0);
    adv_to(298);
    chk("sync_ch0_high_298", 32'(clk_out[0]), 32'd1);
    adv_to(323);
    chk("sync_tick_323", 32'(tick), 32'b01);
    chk("sync_clk_323", 32'(clk_out), 32'b10);

    // 6. reset with ch0 pending N=6,H=3
    adv_to(330);
    drive_cfg(1'b1, 2'd0, 26'd6, 26'd3);
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("rst6_ready_pending", 32'(cfg_if.cfg_ready), 32'd0);
    adv_to(335);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst6_clk", 32'(clk_out), 32'b00);
    chk("rst6_tick", 32'(tick), 32'b00);
    chk("rst6_ready", 32'(cfg_if.cfg_ready), 32'd1);
    chk("rst6_err", 32'(cfg_if.cfg_err), 32'd0);
    adv_to(360);
    chk("rst6_low_360", 32'(clk_out), 32'b00);
    adv_to(361);
    chk("rst6_high_361", 32'(clk_out), 32'b11);
    adv_to(386);
    chk("rst6_tick_386", 32'(tick), 32'b11);
    adv_to(392);
    chk("rst6_no_tick_392", 32'(tick), 32'b00);
    chk("rst6_clk_392", 32'(clk_out), 32'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
